// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: blank pattern and hex font.
// All segment patterns are active-low {dp,g,f,e,d,c,b,a}.
package seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Entry n is the glyph for nibble n, dp bit held high (off).
  localparam logic [15:0][7:0] HEX_FONT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    return HEX_FONT[nib];
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble + decimal-point decoder to active-low segment lines.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  logic [7:0] font;

  assign font  = hex_to_seg(nib_i);
  assign seg_o = {~dp_i, font[6:0]};

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed NUM_DIGITS hex scanner with a one-entry pending buffer swapped in at frame boundaries.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZ_BLANK_EN.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data_valid,
  input  logic [4*NUM_DIGITS-1:0] data,
  output logic                    data_ready,
  input  logic [NUM_DIGITS-1:0]   dig_blank,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [NUM_DIGITS-1:0]   led_en,
  output logic                    led_ca,
  output logic                    led_cb,
  output logic                    led_cc,
  output logic                    led_cd,
  output logic                    led_ce,
  output logic                    led_cf,
  output logic                    led_cg,
  output logic                    led_dp
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = 4 * NUM_DIGITS;

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         disp_q, disp_d, pend_q, pend_d;
  logic                  pend_full_q, pend_full_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic [7:0]            seg_q, seg_d, dec_seg;
  logic                  tick, frame, take, blank;

  assign tick       = (presc_q == PW'(SCAN_DIV - 1));
  assign frame      = tick && (idx_q == IW'(NUM_DIGITS - 1));
  assign data_ready = ~pend_full_q & ~rst;
  assign take       = data_valid & data_ready;

  seg_hex_decoder u_dec (
    .nib_i (disp_q[{idx_q, 2'b00} +: 4]),
    .dp_i  (dp_mask[idx_q]),
    .seg_o (dec_seg)
  );

`ifdef SEG_SCAN_LZ_BLANK_EN
  // Digit is a leading zero when it and every more-significant nibble are zero.
  logic [DW-1:0] upper;
  assign upper = disp_q >> {idx_q, 2'b00};
  assign blank = dig_blank[idx_q] | ((idx_q != '0) && (upper == '0));
`else
  assign blank = dig_blank[idx_q];
`endif

  always_comb begin
    presc_d     = tick ? '0 : presc_q + 1'b1;
    idx_d       = idx_q;
    disp_d      = disp_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    if (tick) idx_d = frame ? '0 : idx_q + 1'b1;
    // A capture needs an empty buffer, so it never coincides with a swap.
    if (frame && pend_full_q) begin
      disp_d      = pend_q;
      pend_full_d = 1'b0;
    end
    if (take) begin
      pend_d      = data;
      pend_full_d = 1'b1;
    end
    en_d  = blank ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    seg_d = blank ? SEG_OFF : dec_seg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= '0;
      idx_q       <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      en_q        <= '1;
      seg_q       <= SEG_OFF;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      en_q        <= en_d;
      seg_q       <= seg_d;
    end
  end

  assign led_en = en_q;
  assign {led_dp, led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca} = seg_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display (8 digits, 4 cycles per digit); timing tracked by a cycle count from reset.
`timescale 1ns/1ps
module tb_seg_scan_display;

  logic        clk = 1'b0, rst = 1'b1, data_valid = 1'b0;
  logic [31:0] data = '0;
  logic        data_ready;
  logic [7:0]  dig_blank = '0, dp_mask = '0, led_en, seg;
  logic        led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg, led_dp;
  int          checks = 0, errors = 0, cyc = 0;

  seg_scan_display #(.NUM_DIGITS(8), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data(data), .data_ready(data_ready),
    .dig_blank(dig_blank), .dp_mask(dp_mask), .led_en(led_en),
    .led_ca(led_ca), .led_cb(led_cb), .led_cc(led_cc), .led_cd(led_cd),
    .led_ce(led_ce), .led_cf(led_cf), .led_cg(led_cg), .led_dp(led_dp)
  );

  assign seg = {led_dp, led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca};

  always #5 clk = ~clk;
  // Edges since the last reset edge; output after edge c shows digit ((c-1)/4)%8.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic wait_to(input int c);
    int n = 0;
    while (cyc != c && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (cyc != c) begin
      errors++;
      $display("FAIL wait_to: cyc=%0d required %0d", cyc, c);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks += 3;
      if (led_en !== 8'hFF) begin errors++; $display("FAIL reset_en: got %h exp ff", led_en); end
      if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg: got %h exp ff", seg); end
      if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b exp 0", data_ready); end
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (data_ready !== 1'b1) begin errors++; $display("FAIL reset_rel_rdy: got %b exp 1", data_ready); end
  endtask

  task automatic test_scan();
    logic [7:0] es [8];
    int d;
    es = '{8'h80, 8'hF9, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h92, 8'hA4};
    data = 32'h2500_0018; data_valid = 1'b1;
    wait_to(1);
    data_valid = 1'b0;
    checks += 3;
    if (data_ready !== 1'b0) begin errors++; $display("FAIL scan_rdy_drop: got %b exp 0", data_ready); end
    if (seg !== 8'hC0) begin errors++; $display("FAIL scan_first_seg: got %h exp c0", seg); end
    if (led_en !== 8'hFE) begin errors++; $display("FAIL scan_first_en: got %h exp fe", led_en); end
    wait_to(32);
    checks++;
    if (data_ready !== 1'b1) begin errors++; $display("FAIL scan_rdy_swap: got %b exp 1", data_ready); end
    for (int c = 33; c <= 64; c++) begin
      wait_to(c);
      d = ((c - 1) / 4) % 8;
      checks += 2;
      if (seg !== es[d]) begin errors++; $display("FAIL scan_seg c=%0d: got %h exp %h", c, seg, es[d]); end
      if (led_en !== (8'hFF ^ (8'h01 << d))) begin
        errors++; $display("FAIL scan_en c=%0d: got %h exp %h", c, led_en, 8'hFF ^ (8'h01 << d));
      end
    end
  endtask

  task automatic test_handshake();
    int d;
    wait_to(65);
    checks++;
    if (data_ready !== 1'b1) begin errors++; $display("FAIL hs_rdy_a: got %b exp 1", data_ready); end
    data = 32'hAAAA_AAAA; data_valid = 1'b1;
    wait_to(66);
    data = 32'hBBBB_BBBB;
    checks++;
    if (data_ready !== 1'b0) begin errors++; $display("FAIL hs_rdy_full: got %b exp 0", data_ready); end
    wait_to(95);
    data_valid = 1'b0;
    wait_to(96);
    checks++;
    if (data_ready !== 1'b1) begin errors++; $display("FAIL hs_rdy_swap: got %b exp 1", data_ready); end
    for (int c = 97; c <= 128; c++) begin
      wait_to(c);
      if (c == 97) data_valid = 1'b1;
      if (c == 98) data_valid = 1'b0;
      d = ((c - 1) / 4) % 8;
      checks += 2;
      if (seg !== 8'h88) begin errors++; $display("FAIL hs_frame_a c=%0d: got %h exp 88", c, seg); end
      if (led_en !== (8'hFF ^ (8'h01 << d))) begin
        errors++; $display("FAIL hs_en c=%0d: got %h exp %h", c, led_en, 8'hFF ^ (8'h01 << d));
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 129; c <= 192; c++) begin
      wait_to(c);
      if (c == 159) begin data = 32'h1234_5678; data_valid = 1'b1; end
      if (c == 160) begin
        data_valid = 1'b0;
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("FAIL b2b_cap_on_tick: rdy %b exp 0", data_ready); end
      end
      checks++;
      if (seg !== 8'h83) begin errors++; $display("FAIL b2b_frame_b c=%0d: got %h exp 83", c, seg); end
    end
  endtask

  task automatic test_blank();
    logic [7:0] es [8];
    logic [7:0] ee [8];
    int d;
    es = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    ee = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    dig_blank = 8'h0F; dp_mask = 8'h01;
    for (int c = 193; c <= 224; c++) begin
      wait_to(c);
      d = ((c - 1) / 4) % 8;
      checks += 2;
      if (seg !== es[d]) begin errors++; $display("FAIL blank_seg c=%0d: got %h exp %h", c, seg, es[d]); end
      if (led_en !== ee[d]) begin errors++; $display("FAIL blank_en c=%0d: got %h exp %h", c, led_en, ee[d]); end
    end
    dig_blank = 8'h00;
    for (int c = 225; c <= 232; c++) begin
      wait_to(c);
      checks += 2;
      if (seg !== ((c <= 228) ? 8'h00 : 8'hF8)) begin
        errors++; $display("FAIL dp_seg c=%0d: got %h exp %h", c, seg, (c <= 228) ? 8'h00 : 8'hF8);
      end
      if (led_en !== ((c <= 228) ? 8'hFE : 8'hFD)) begin
        errors++; $display("FAIL dp_en c=%0d: got %h exp %h", c, led_en, (c <= 228) ? 8'hFE : 8'hFD);
      end
    end
  endtask

  task automatic test_lz();
    logic [7:0] es1 [8];
    logic [7:0] es0 [8];
    logic [7:0] ee1 [8];
    logic [7:0] ee0 [8];
    int d;
`ifdef SEG_SCAN_LZ_BLANK_EN
    es1 = '{8'h80, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    ee1 = '{8'hFE, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    es0 = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    ee0 = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`else
    es1 = '{8'h80, 8'hF9, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
    ee1 = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    es0 = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
    ee0 = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
`endif
    wait_to(233);
    dp_mask = 8'h00; data = 32'h0000_0018; data_valid = 1'b1;
    wait_to(234);
    data_valid = 1'b0;
    for (int c = 257; c <= 320; c++) begin
      wait_to(c);
      if (c == 257) begin data = 32'h0; data_valid = 1'b1; end
      if (c == 258) data_valid = 1'b0;
      d = ((c - 1) / 4) % 8;
      checks += 2;
      if (c <= 288) begin
        if (seg !== es1[d]) begin errors++; $display("FAIL lz18_seg c=%0d: got %h exp %h", c, seg, es1[d]); end
        if (led_en !== ee1[d]) begin errors++; $display("FAIL lz18_en c=%0d: got %h exp %h", c, led_en, ee1[d]); end
      end else begin
        if (seg !== es0[d]) begin errors++; $display("FAIL lz0_seg c=%0d: got %h exp %h", c, seg, es0[d]); end
        if (led_en !== ee0[d]) begin errors++; $display("FAIL lz0_en c=%0d: got %h exp %h", c, led_en, ee0[d]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] es [8];
    int d;
`ifdef SEG_SCAN_LZ_BLANK_EN
    es = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`else
    es = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif
    wait_to(321);
    data = 32'hFFFF_FFFF; data_valid = 1'b1;
    wait_to(322);
    data_valid = 1'b0;
    checks++;
    if (data_ready !== 1'b0) begin errors++; $display("FAIL rmid_full: rdy %b exp 0", data_ready); end
    wait_to(330);
    rst = 1'b1;
    @(negedge clk);
    checks += 3;
    if (led_en !== 8'hFF) begin errors++; $display("FAIL rmid_en: got %h exp ff", led_en); end
    if (seg !== 8'hFF) begin errors++; $display("FAIL rmid_seg: got %h exp ff", seg); end
    if (data_ready !== 1'b0) begin errors++; $display("FAIL rmid_rdy: got %b exp 0", data_ready); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (data_ready !== 1'b1) begin errors++; $display("FAIL rmid_rel_rdy: got %b exp 1", data_ready); end
    for (int c = 1; c <= 36; c++) begin
      wait_to(c);
      d = ((c - 1) / 4) % 8;
      checks++;
      if (seg !== es[d]) begin errors++; $display("FAIL rmid_disp c=%0d: got %h exp %h", c, seg, es[d]); end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_handshake();
    test_back_to_back();
    test_blank();
    test_lz();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
Parametrised multiplexed seven-segment scanner, the successor to the fixed 8-digit DISPLAY. It drives NUM_DIGITS hex digits from a 4*NUM_DIGITS-bit value. The value is loaded through a valid/ready handshake into a one-entry pending buffer, so a displayed frame never mixes old and new data. It sits at board top level, fed from CPU-side debug registers (e.g. x8) or MMIO, and clocked at the board clock independent of the CPU clock.

Parameters:
NUM_DIGITS, 8, number of digits scanned (1..16).
SCAN_DIV, 100000, clk cycles each digit is held (>=2); 100000 gives 1 kHz per digit at 100 MHz.

Ports:
clk  in  1  board clock.
rst  in  1  synchronous, active-high reset.
data_valid  in  1  new value offered.
data  in  4*NUM_DIGITS  value; nibble i drives digit i; digit 0 is the least significant nibble.
data_ready  out  1  pending buffer empty, can accept.
dig_blank  in  NUM_DIGITS  per-digit force-off mask, sampled live.
dp_mask  in  NUM_DIGITS  per-digit decimal point on, sampled live.
led_en  out  NUM_DIGITS  digit enables, active-low, one-hot-low or all high.
led_ca..led_cg  out  1 each  segments a..g, active-low.
led_dp  out  1  decimal point, active-low.

Behaviour:
- Reset (rst high at a clk edge): prescaler 0, digit index 0, display reg 0, pending empty, data_ready 0, led_en all 1, all segments and dp 1 (dark). data_ready goes to 1 in the first cycle after rst deasserts.
- Prescaler counts 0..SCAN_DIV-1 and wraps. tick = (prescaler == SCAN_DIV-1).
- On tick, index increments. At index NUM_DIGITS-1 it wraps to 0; this wrap is the frame boundary.
- Handshake:
  - data_ready = pending empty and not in reset.
  - On data_valid & data_ready, capture data into pending and mark it full. data_ready drops the next cycle.
  - data is ignored when data_ready = 0. No back-pressure timeout.
- Frame boundary with pending full: display reg <= pending, pending cleared, data_ready = 1 the next cycle. The new digit 0 shows the new value immediately.
- Capture on the same cycle as a boundary tick: pending was empty, so the value is captured and waits for the next boundary. It is never loaded directly into the display reg.
- Outputs are registered and update the cycle after the index changes (one-cycle latency from tick).
- Digit i displayed (index = i):
  - If blank_i: led_en all 1, segments all 1.
  - Otherwise: led_en[i] = 0, others 1; segments = font(nibble i); led_dp = ~dp_mask[i].
- blank_i = dig_blank[i] (plus LZ rule below).
- Font, active-low {dp,g,f,e,d,c,b,a} with dp = 1:
  0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
- Reset mid-frame: takes effect on the next edge, and any pending value is discarded.

Optional Feature:
Macro SEG_SCAN_LZ_BLANK_EN.
- Defined: leading-zero blanking. Digit i is also blanked when i > 0 and all nibbles i..NUM_DIGITS-1 of the display reg are 0. Digit 0 is never LZ-blanked. Computed from the display reg, not pending.
- Undefined: all digits show their nibble, zeros included; blanking comes from dig_blank only.

Decomposition:
- Package seg_pkg holds:
  - SEG_OFF = 8'hFF.
  - 16-entry hex font constant and a function hex_to_seg(nibble) returning the active-low {dp,g,f,e,d,c,b,a}.
  - Enum-free index width via $clog2(NUM_DIGITS) computed locally.
- One sub-module, seg_hex_decoder: combinational nibble+dp -> 8 segment lines. It wraps hex_to_seg so that it can be unit-tested alone.

Test Plan:
- Reset: hold rst 3 cycles -> led_en=8'hFF, segments=FF, data_ready=0 during rst, 1 the cycle after release.
- SCAN_DIV=4, load 32'h2500_0018 -> after the next frame boundary, over 8 ticks: digit0 seg=80 led_en=FE, digit1=F9, digit2..5=C0, digit6=92, digit7=A4; each digit is held exactly 4 cycles.
- Handshake: load A, then offer B while data_ready=0 -> B is ignored. Offer B after the boundary -> B is accepted. The display never shows a mix of A and B nibbles within one frame.
- dig_blank=8'h0F, dp_mask=8'h01, value 32'h1234_5678 -> digits 0-3 have led_en all 1; digit4=99, digit7=F9, and digit0 is dark (its dp is suppressed by the blank).
- With SEG_SCAN_LZ_BLANK_EN, value 32'h0000_0018 -> only digits 0 (80) and 1 (F9) are lit. Value 0 -> only digit0 is lit, showing C0.
- Assert rst mid-frame with pending full -> all dark next cycle; after release data_ready=1 and the display shows 0 (C0 on every digit, or digit0 only with LZ).
